bus_bridge_uart_frame_codec: RTL and testbench
==============================================

Name: bus_bridge_uart_frame_codec

Overview:
Parametrised byte-stream codec between a UART byte interface and the bus bridge initiator request/response channels.
- Generalises the fixed 16-bit-address / 8-bit-data framing to ADDR_W / DATA_W.
- Adds a request FIFO so the UART keeps receiving while the bridge is busy.
- Adds an inter-byte gap timeout that discards partial frames.
- Adds a saturating drop counter.
- Sits between the uart instance and bus_bridge_initiator_if inside the next-generation initiator wrapper.

Parameters:
- ADDR_W, 16, address width; multiple of 8, range 8..32.
- DATA_W, 8, data width; multiple of 8, range 8..32.
- REQ_DEPTH, 4, request FIFO entries; power of two, at least 2.
- GAP_TIMEOUT, 1024, idle cycles allowed between bytes of one frame before the frame is discarded; at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts the byte this cycle
- req_valid  out  1  FIFO head valid
- req_ready  in  1  bridge accepts the head
- req_addr  out  ADDR_W  head address
- req_wdata  out  DATA_W  head write data
- req_is_write  out  1  head direction
- resp_valid  in  1  response valid
- resp_ready  out  1  codec can accept a response
- resp_rdata  in  DATA_W  read data
- resp_is_write  in  1  direction echo
- fifo_level  out  $clog2(REQ_DEPTH)+1  occupied entries
- drop_count  out  8  dropped frames, saturating

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Outputs: tx_valid=0, tx_data=0, req_valid=0, resp_ready=1 (next cycle), fifo_level=0, drop_count=0.
  - Both FSMs go to IDLE and the FIFO empties.
  - A partial rx frame or in-flight tx frame is discarded without being counted.
- Definitions: AB = ADDR_W/8, DB = DATA_W/8.
- Request frame, in order:
  - AB address bytes, LSB first;
  - DB write-data bytes, LSB first;
  - one flags byte: bit0 = is_write, bits 7:1 ignored.
  - Bytes are consumed only on rx_valid.
- RX FSM, states RX_IDLE, RX_ADDR, RX_DATA, RX_FLAGS, RX_CSUM:
  - A byte index counter shifts bytes into an assembly register.
  - RX_IDLE goes to RX_ADDR on the first byte, which is stored.
  - RX_ADDR goes to RX_DATA after byte AB-1.
  - RX_DATA goes to RX_FLAGS after byte DB-1.
  - The flags byte completes the frame and the FSM returns to RX_IDLE the same edge.
- Push on frame completion:
  - Push if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the frame and increment drop_count.
  - Latency: flags byte at edge N gives req_valid=1 from cycle N+1 when the FIFO was empty.
- Gap timer:
  - Cleared on every rx_valid; counts while the RX FSM is not in RX_IDLE.
  - On reaching GAP_TIMEOUT-1: return to RX_IDLE, increment drop_count, keep FIFO contents.
  - rx_valid in the same cycle as the timeout is treated as the first byte of a new frame.
- FIFO: first-word-fall-through.
  - req_valid = !empty; req_* = head entry.
  - Pop on req_valid && req_ready.
  - Head payload is stable while req_valid=1 and req_ready=0.
  - fifo_level updates the cycle after a push or pop; simultaneous push+pop leaves it unchanged.
- drop_count saturates at 255. Multiple drop causes in one cycle count as one.
- Response frame, in order:
  - DB read-data bytes, LSB first;
  - flags byte {7'b0, resp_is_write}.
- TX FSM, states TX_IDLE, TX_DATA, TX_FLAGS, TX_CSUM:
  - resp_ready = (state == TX_IDLE).
  - Handshake resp_valid && resp_ready captures rdata and is_write.
  - tx_valid rises the next cycle with byte 0.
  - tx_data/tx_valid hold until tx_ready; the index advances on each handshake.
  - After the flags handshake the FSM is in TX_IDLE and resp_ready=1 on the next cycle.
  - No back-to-back overlap between response frames.
- RX and TX are independent; any interleaving is legal.

Optional Feature:
- Macro: BUS_BRIDGE_UART_CHECKSUM_EN.
- Defined:
  - Each frame carries a trailing checksum byte, equal to the XOR of all preceding bytes of that frame.
  - RX_CSUM follows RX_FLAGS. A checksum mismatch drops the frame and increments drop_count.
  - TX_CSUM follows TX_FLAGS and sends the computed XOR.
- Undefined: the RX_CSUM/TX_CSUM states and checksum logic are absent; frames end at the flags byte.

Decomposition:
- bus_bridge_pkg gains:
  - BB_FLAG_WRITE_BIT = 0;
  - rx/tx state enum typedefs;
  - a parametrisable packed request struct (addr, wdata, is_write) for the FIFO entry.
- One sub-module, bus_bridge_req_fifo:
  - synchronous FWFT FIFO with WIDTH and DEPTH parameters;
  - push/pop/full/empty/level ports.

Test Plan:
- Defaults; rx bytes 34 12 A5 01 -> req_valid at N+1 with addr=16'h1234, wdata=8'hA5, is_write=1; held stable while req_ready=0.
- req_ready=0; send 5 complete read frames -> fifo_level=4, drop_count=1; after 4 pops, addresses are returned in send order.
- Send 34 12, then idle 1024 cycles -> drop_count=1, no req_valid; next full frame accepted normally.
- resp_rdata=8'h5A, is_write=0, tx_ready stalled 3 cycles per byte -> tx bytes 5A 00 in order, tx_data stable while stalled, resp_ready=0 until done.
- ADDR_W=24, DATA_W=16; rx 56 34 12 CD AB 00 -> addr=24'h123456, wdata=16'hABCD, is_write=0.
- Checksum macro on; rx 34 12 A5 01 with checksum 82 -> accepted; same frame with checksum 00 -> dropped, drop_count=1; rst=1 mid-frame -> fifo_level=0, drop_count=0.

Source files
------------

// File: rtl/bus_bridge_pkg.sv
// rtl/bus_bridge_pkg.sv - shared types and constants for the bus bridge UART frame codec
//
// Purpose: flag-bit position, RX/TX frame FSM state encodings and the request
// entry layout shared by the codec and its request FIFO.
// Optional feature macro: BUS_BRIDGE_UART_CHECKSUM_EN adds the RX_CSUM/TX_CSUM states.
// Ports: none (package).

package bus_bridge_pkg;

    // Position of the direction bit inside request and response flags bytes.
    localparam int BB_FLAG_WRITE_BIT = 0;

    // Widest address/data the codec supports.
    localparam int BB_MAX_ADDR_W = 32;
    localparam int BB_MAX_DATA_W = 32;

`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ADDR,
        RX_DATA,
        RX_FLAGS,
        RX_CSUM
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DATA,
        TX_FLAGS,
        TX_CSUM
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ADDR,
        RX_DATA,
        RX_FLAGS
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DATA,
        TX_FLAGS
    } tx_state_e;
`endif

    // Request entry at the widest configuration. Packages cannot take
    // parameters, so the codec declares a same-shaped struct narrowed to its
    // own ADDR_W/DATA_W; fields keep this order (addr, wdata, is_write).
    typedef struct packed {
        logic [BB_MAX_ADDR_W-1:0] addr;
        logic [BB_MAX_DATA_W-1:0] wdata;
        logic                     is_write;
    } bb_req_t;

    // Width of one request entry for a given address/data width.
    function automatic int bb_req_width(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

endpackage

// File: rtl/bus_bridge_req_fifo.sv
// rtl/bus_bridge_req_fifo.sv - synchronous first-word-fall-through request FIFO
//
// Purpose: holds assembled requests until the bridge accepts them.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   push, push_data    write an entry (ignored when full unless popping the same cycle)
//   pop                remove the head entry (ignored when empty)
//   head_data          current head entry, valid while !empty
//   full, empty        occupancy flags
//   level              number of occupied entries

module bus_bridge_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (level_q != '0);
        // A full FIFO still accepts a push when the head leaves the same cycle.
        do_push = push && ((level_q != FULL_LVL) || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible through level_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign level     = level_q;

endmodule

// File: rtl/bus_bridge_uart_frame_codec.sv
// rtl/bus_bridge_uart_frame_codec.sv - UART byte stream to bus bridge request/response codec
//
// Purpose: assembles request frames (addr LSB-first, wdata LSB-first, flags)
// from received bytes into a request FIFO, and serialises responses
// (rdata LSB-first, flags) into transmit bytes.
// Optional feature macro: BUS_BRIDGE_UART_CHECKSUM_EN appends an XOR checksum
// byte to every frame in both directions.
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   rx_data, rx_valid                    received byte strobe
//   tx_data, tx_valid, tx_ready          transmit byte handshake
//   req_valid, req_ready, req_addr,
//   req_wdata, req_is_write              request FIFO head towards the bridge
//   resp_valid, resp_ready, resp_rdata,
//   resp_is_write                        response from the bridge
//   fifo_level                           occupied request entries
//   drop_count                           saturating count of discarded frames

module bus_bridge_uart_frame_codec
    import bus_bridge_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int REQ_DEPTH   = 4,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [ADDR_W-1:0]            req_addr,
    output logic [DATA_W-1:0]            req_wdata,
    output logic                         req_is_write,
    input  logic                         resp_valid,
    output logic                         resp_ready,
    input  logic [DATA_W-1:0]            resp_rdata,
    input  logic                         resp_is_write,
    output logic [$clog2(REQ_DEPTH):0]   fifo_level,
    output logic [7:0]                   drop_count
);

    localparam int AB    = ADDR_W / 8;
    localparam int DB    = DATA_W / 8;
    localparam int PAY_W = ADDR_W + DATA_W;
    localparam int GAP_W = $clog2(GAP_TIMEOUT) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [1:0] AB_LAST = 2'(AB - 1);
    localparam logic [1:0] DB_LAST = 2'(DB - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              is_write;
    } req_t;

    // ---------------- RX side ----------------
    rx_state_e        rx_state_q, rx_state_d, rx_cur;
    logic [1:0]       rx_idx_q, rx_idx_d;
    logic [PAY_W-1:0] asm_q, asm_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       drop_q, drop_d;
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
    logic [7:0]       rx_csum_q, rx_csum_d;
    logic             rx_flag_q, rx_flag_d;
`endif
    logic             gap_timeout, frame_done, frame_is_write, csum_bad;
    logic             drop_full, drop_ev;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    req_t             push_entry, head_entry;

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_idx_d       = rx_idx_q;
        asm_d          = asm_q;
        frame_done     = 1'b0;
        csum_bad       = 1'b0;
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
        rx_csum_d      = rx_csum_q;
        rx_flag_d      = rx_flag_q;
        frame_is_write = rx_flag_q;
`else
        frame_is_write = rx_data[BB_FLAG_WRITE_BIT];
`endif

        // The timeout abandons the partial frame; a byte arriving the same
        // cycle is handled as if the FSM were already idle.
        gap_timeout = (rx_state_q != RX_IDLE) && (gap_q == GAP_LAST);
        rx_cur      = gap_timeout ? RX_IDLE : rx_state_q;
        if (gap_timeout) begin
            rx_state_d = RX_IDLE;
        end

        if (rx_valid) begin
            case (rx_cur)
                RX_IDLE: begin
                    asm_d = {rx_data, asm_q[PAY_W-1:8]};
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
                    rx_csum_d = rx_data;
`endif
                    if (AB == 1) begin
                        rx_state_d = RX_DATA;
                        rx_idx_d   = 2'd0;
                    end else begin
                        rx_state_d = RX_ADDR;
                        rx_idx_d   = 2'd1;
                    end
                end
                RX_ADDR: begin
                    asm_d = {rx_data, asm_q[PAY_W-1:8]};
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
                    rx_csum_d = rx_csum_q ^ rx_data;
`endif
                    if (rx_idx_q == AB_LAST) begin
                        rx_state_d = RX_DATA;
                        rx_idx_d   = 2'd0;
                    end else begin
                        rx_idx_d = rx_idx_q + 2'd1;
                    end
                end
                RX_DATA: begin
                    asm_d = {rx_data, asm_q[PAY_W-1:8]};
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
                    rx_csum_d = rx_csum_q ^ rx_data;
`endif
                    if (rx_idx_q == DB_LAST) begin
                        rx_state_d = RX_FLAGS;
                        rx_idx_d   = 2'd0;
                    end else begin
                        rx_idx_d = rx_idx_q + 2'd1;
                    end
                end
                RX_FLAGS: begin
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
                    rx_flag_d  = rx_data[BB_FLAG_WRITE_BIT];
                    rx_csum_d  = rx_csum_q ^ rx_data;
                    rx_state_d = RX_CSUM;
`else
                    frame_done = 1'b1;
                    rx_state_d = RX_IDLE;
`endif
                end
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
                RX_CSUM: begin
                    rx_state_d = RX_IDLE;
                    if ((rx_csum_q ^ rx_data) == 8'h00) begin
                        frame_done = 1'b1;
                    end else begin
                        csum_bad = 1'b1;
                    end
                end
`endif
                default: rx_state_d = RX_IDLE;
            endcase
        end

        if (rx_valid || (rx_state_q == RX_IDLE) || gap_timeout) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + 1'b1;
        end

        fifo_pop  = req_valid && req_ready;
        drop_full = frame_done && fifo_full && !fifo_pop;
        fifo_push = frame_done && !drop_full;

        // Simultaneous drop causes collapse into a single increment.
        drop_ev = gap_timeout || drop_full || csum_bad;
        if (drop_ev && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        push_entry.addr     = asm_q[ADDR_W-1:0];
        push_entry.wdata    = asm_q[PAY_W-1:ADDR_W];
        push_entry.is_write = frame_is_write;
    end

    bus_bridge_req_fifo #(
        .WIDTH (bb_req_width(ADDR_W, DATA_W)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign req_valid    = !fifo_empty;
    assign req_addr     = head_entry.addr;
    assign req_wdata    = head_entry.wdata;
    assign req_is_write = head_entry.is_write;
    assign drop_count   = drop_q;

    // ---------------- TX side ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_is_write_q, tx_is_write_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_csum_q, tx_csum_d;
    logic [DATA_W-1:0] tx_next;
    logic [7:0]        tx_flags;

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_idx_d      = tx_idx_q;
        tx_shift_d    = tx_shift_q;
        tx_is_write_d = tx_is_write_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        tx_csum_d     = tx_csum_q;
        tx_next       = tx_shift_q >> 8;
        tx_flags      = {7'b0, tx_is_write_q};

        // tx_csum_q tracks the XOR of every byte loaded into tx_data so far.
        case (tx_state_q)
            TX_IDLE: begin
                if (resp_valid) begin
                    tx_shift_d    = resp_rdata;
                    tx_is_write_d = resp_is_write;
                    tx_data_d     = resp_rdata[7:0];
                    tx_csum_d     = resp_rdata[7:0];
                    tx_valid_d    = 1'b1;
                    tx_idx_d      = 2'd0;
                    tx_state_d    = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_ready) begin
                    if (tx_idx_q == DB_LAST) begin
                        tx_data_d  = tx_flags;
                        tx_csum_d  = tx_csum_q ^ tx_flags;
                        tx_state_d = TX_FLAGS;
                    end else begin
                        tx_shift_d = tx_next;
                        tx_data_d  = tx_next[7:0];
                        tx_csum_d  = tx_csum_q ^ tx_next[7:0];
                        tx_idx_d   = tx_idx_q + 2'd1;
                    end
                end
            end
            TX_FLAGS: begin
                if (tx_ready) begin
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
                    tx_data_d  = tx_csum_q;
                    tx_state_d = TX_CSUM;
`else
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    tx_state_d = TX_IDLE;
`endif
                end
            end
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
            TX_CSUM: begin
                if (tx_ready) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            end
`endif
            default: begin
                tx_valid_d = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign resp_ready = (tx_state_q == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_idx_q      <= '0;
            asm_q         <= '0;
            gap_q         <= '0;
            drop_q        <= '0;
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
            rx_csum_q     <= '0;
            rx_flag_q     <= 1'b0;
`endif
            tx_state_q    <= TX_IDLE;
            tx_idx_q      <= '0;
            tx_shift_q    <= '0;
            tx_is_write_q <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_csum_q     <= '0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_idx_q      <= rx_idx_d;
            asm_q         <= asm_d;
            gap_q         <= gap_d;
            drop_q        <= drop_d;
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
            rx_csum_q     <= rx_csum_d;
            rx_flag_q     <= rx_flag_d;
`endif
            tx_state_q    <= tx_state_d;
            tx_idx_q      <= tx_idx_d;
            tx_shift_q    <= tx_shift_d;
            tx_is_write_q <= tx_is_write_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_csum_q     <= tx_csum_d;
        end
    end

endmodule

// File: tb/tb_bus_bridge_uart_frame_codec.sv
// tb/tb_bus_bridge_uart_frame_codec.sv - directed self-checking bench for bus_bridge_uart_frame_codec

module tb_bus_bridge_uart_frame_codec;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_is_write;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_rdata;
    logic        resp_is_write;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    // Second instance at ADDR_W=24 / DATA_W=16 sharing the rx stream.
    logic [7:0]  w_tx_data;
    logic        w_tx_valid;
    logic        w_req_valid;
    logic [23:0] w_req_addr;
    logic [15:0] w_req_wdata;
    logic        w_req_is_write;
    logic        w_resp_ready;
    logic [2:0]  w_fifo_level;
    logic [7:0]  w_drop_count;
    logic [15:0] w_resp_rdata = 16'h0000;
    logic        w_resp_valid = 1'b0;
    logic        w_resp_is_write = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
    localparam int NTX = 3;
`else
    localparam int NTX = 2;
`endif
    logic [7:0] tx_exp [3];

    always #5 clk = ~clk;

    bus_bridge_uart_frame_codec dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_is_write(req_is_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_is_write(resp_is_write), .fifo_level(fifo_level), .drop_count(drop_count)
    );

    bus_bridge_uart_frame_codec #(.ADDR_W(24), .DATA_W(16)) dut_w (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(tx_ready),
        .req_valid(w_req_valid), .req_ready(req_ready), .req_addr(w_req_addr),
        .req_wdata(w_req_wdata), .req_is_write(w_req_is_write),
        .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_rdata(w_resp_rdata),
        .resp_is_write(w_resp_is_write), .fifo_level(w_fifo_level), .drop_count(w_drop_count)
    );

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; req_ready = 1'b0; tx_ready = 1'b0;
        resp_valid = 1'b0; resp_rdata = 8'h00; resp_is_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // bytes holds the frame LSB-first (byte 0 in bits 7:0); checksum appended when enabled.
    task automatic send_frame(input logic [47:0] bytes, input int n, input bit pop_last);
        logic [7:0] x;
        logic [7:0] b;
        int total;
        x = 8'h00;
        total = n;
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
        total = n + 1;
`endif
        for (int i = 0; i < total; i++) begin
            b = (i < n) ? bytes[8*i +: 8] : x;
            x = x ^ b;
            if (pop_last && (i == total - 1)) req_ready = 1'b1;
            send_byte(b);
        end
        if (pop_last) req_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({tx_valid, tx_data, req_valid, resp_ready, fifo_level, drop_count} !== {1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset: got tx_valid=%b tx_data=%h req_valid=%b resp_ready=%b level=%0d drops=%0d want 0 00 0 1 0 0",
                     tx_valid, tx_data, req_valid, resp_ready, fifo_level, drop_count);
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hA5);
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
        send_byte(8'h01);
`endif
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", req_valid); end
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
        send_byte(8'h82);
`else
        send_byte(8'h01);
`endif
        n_tests++;
        if ({req_valid, req_addr, req_wdata, req_is_write} !== {1'b1, 16'h1234, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_head: got v=%b a=%h d=%h w=%b want 1 1234 a5 1", req_valid, req_addr, req_wdata, req_is_write);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({req_valid, req_addr, req_wdata, req_is_write, fifo_level} !== {1'b1, 16'h1234, 8'hA5, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL basic_hold: got v=%b a=%h d=%h w=%b lvl=%0d want 1 1234 a5 1 1",
                     req_valid, req_addr, req_wdata, req_is_write, fifo_level);
        end
        req_ready = 1'b1; @(posedge clk); #1; req_ready = 1'b0;
        n_tests++;
        if ({req_valid, fifo_level} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL basic_pop: got v=%b lvl=%0d want 0 0", req_valid, fifo_level);
        end
    endtask

    task automatic test_fifo_full_drop();
        logic [7:0] i8;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            i8 = 8'(i);
            send_frame({16'h0000, 8'h00, i8, 8'h01, i8}, 4, 1'b0);
        end
        n_tests++;
        if ({fifo_level, drop_count} !== {3'd4, 8'd1}) begin
            n_fail++; $display("FAIL full_drop: got lvl=%0d drops=%0d want 4 1", fifo_level, drop_count);
        end
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({req_valid, req_addr, req_wdata} !== {1'b1, 16'h0100 + 16'(i), 8'(i)}) begin
                n_fail++;
                $display("FAIL full_order%0d: got v=%b a=%h d=%h want 1 %h %h", i, req_valid, req_addr, req_wdata, 16'h0100 + 16'(i), 8'(i));
            end
            @(posedge clk); #1;
        end
        req_ready = 1'b0;
        n_tests++;
        if ({req_valid, fifo_level} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL full_drained: got v=%b lvl=%0d want 0 0", req_valid, fifo_level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] i8;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            i8 = 8'(i);
            send_frame({16'h0000, 8'h01, i8, 8'h02, i8}, 4, (i == 4));
        end
        n_tests++;
        if ({fifo_level, drop_count, req_addr} !== {3'd4, 8'd0, 16'h0201}) begin
            n_fail++;
            $display("FAIL push_pop_full: got lvl=%0d drops=%0d head=%h want 4 0 0201", fifo_level, drop_count, req_addr);
        end
        req_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_tests++;
            if ({req_valid, req_addr, req_is_write} !== {1'b1, 16'h0200 + 16'(i), 1'b1}) begin
                n_fail++;
                $display("FAIL push_pop_order%0d: got v=%b a=%h w=%b want 1 %h 1", i, req_valid, req_addr, req_is_write, 16'h0200 + 16'(i));
            end
            @(posedge clk); #1;
        end
        req_ready = 1'b0;
    endtask

    task automatic test_gap_timeout();
        do_reset();
        send_byte(8'h34); send_byte(8'h12);
        repeat (1023) @(posedge clk);
        #1;
        n_tests++;
        if (drop_count !== 8'd0) begin n_fail++; $display("FAIL gap_early: got drops=%0d want 0", drop_count); end
        @(posedge clk); #1;
        n_tests++;
        if ({drop_count, req_valid} !== {8'd1, 1'b0}) begin
            n_fail++; $display("FAIL gap_fire: got drops=%0d v=%b want 1 0", drop_count, req_valid);
        end
        send_frame({16'h0000, 8'h00, 8'h11, 8'h56, 8'h78}, 4, 1'b0);
        n_tests++;
        if ({req_valid, req_addr, req_wdata, req_is_write, drop_count} !== {1'b1, 16'h5678, 8'h11, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL gap_next: got v=%b a=%h d=%h w=%b drops=%0d want 1 5678 11 0 1",
                     req_valid, req_addr, req_wdata, req_is_write, drop_count);
        end
        // A byte landing on the timeout edge starts a fresh frame.
        do_reset();
        send_byte(8'h34); send_byte(8'h12);
        repeat (1023) @(posedge clk);
        #1;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h01);
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
        send_byte(8'hDC);
`endif
        n_tests++;
        if ({req_valid, req_addr, req_wdata, req_is_write, drop_count} !== {1'b1, 16'hBBAA, 8'hCC, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL gap_coincident: got v=%b a=%h d=%h w=%b drops=%0d want 1 bbaa cc 1 1",
                     req_valid, req_addr, req_wdata, req_is_write, drop_count);
        end
    endtask

    task automatic test_tx_stall();
        do_reset();
        tx_exp[0] = 8'h5A; tx_exp[1] = 8'h00; tx_exp[2] = 8'h5A;
        resp_rdata = 8'h5A; resp_is_write = 1'b0; resp_valid = 1'b1;
        n_tests++;
        if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_idle: got %b want 1", resp_ready); end
        @(posedge clk); #1;
        resp_valid = 1'b0;
        for (int k = 0; k < NTX; k++) begin
            for (int s = 0; s < 4; s++) begin
                n_tests++;
                if ({tx_valid, tx_data, resp_ready} !== {1'b1, tx_exp[k], 1'b0}) begin
                    n_fail++;
                    $display("FAIL tx_stall_b%0d_c%0d: got v=%b d=%h rr=%b want 1 %h 0", k, s, tx_valid, tx_data, resp_ready, tx_exp[k]);
                end
                if (s < 3) begin @(posedge clk); #1; end
            end
            tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
        end
        n_tests++;
        if ({tx_valid, resp_ready} !== {1'b0, 1'b1}) begin
            n_fail++; $display("FAIL tx_done: got v=%b rr=%b want 0 1", tx_valid, resp_ready);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        do_reset();
        tx_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            resp_rdata    = (r == 0) ? 8'hC3 : 8'h3C;
            resp_is_write = (r == 0);
            tx_exp[0] = resp_rdata;
            tx_exp[1] = {7'b0, resp_is_write};
            tx_exp[2] = tx_exp[0] ^ tx_exp[1];
            resp_valid = 1'b1;
            for (int t = 0; (t < 20) && !resp_ready; t++) begin @(posedge clk); #1; end
            n_tests++;
            if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resp_ready%0d: got %b want 1", r, resp_ready); end
            @(posedge clk); #1;
            resp_valid = 1'b0;
            got = 0;
            for (int t = 0; (t < 20) && (got < NTX); t++) begin
                if (tx_valid) begin
                    n_tests++;
                    if (tx_data !== tx_exp[got]) begin
                        n_fail++; $display("FAIL b2b_r%0d_b%0d: got %h want %h", r, got, tx_data, tx_exp[got]);
                    end
                    got++;
                end
                @(posedge clk); #1;
            end
            n_tests++;
            if (got != NTX) begin n_fail++; $display("FAIL b2b_count%0d: got %0d want %0d", r, got, NTX); end
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got v=%b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_wide();
        do_reset();
        send_frame(48'h00ABCD123456, 6, 1'b0);
        n_tests++;
        if ({w_req_valid, w_req_addr, w_req_wdata, w_req_is_write} !== {1'b1, 24'h123456, 16'hABCD, 1'b0}) begin
            n_fail++;
            $display("FAIL wide: got v=%b a=%h d=%h w=%b want 1 123456 abcd 0", w_req_valid, w_req_addr, w_req_wdata, w_req_is_write);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_frame({16'h0000, 8'h01, 8'h77, 8'h99, 8'h88}, 4, 1'b0);
        send_byte(8'h34); send_byte(8'h12);
        resp_rdata = 8'hEE; resp_valid = 1'b1; @(posedge clk); #1; resp_valid = 1'b0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        n_tests++;
        if ({fifo_level, drop_count, req_valid, tx_valid, resp_ready} !== {3'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_rst: got lvl=%0d drops=%0d v=%b txv=%b rr=%b want 0 0 0 0 1",
                     fifo_level, drop_count, req_valid, tx_valid, resp_ready);
        end
        send_frame({16'h0000, 8'h01, 8'hA5, 8'h12, 8'h34}, 4, 1'b0);
        n_tests++;
        if ({req_valid, req_addr, req_wdata} !== {1'b1, 16'h1234, 8'hA5}) begin
            n_fail++; $display("FAIL mid_rst_next: got v=%b a=%h d=%h want 1 1234 a5", req_valid, req_addr, req_wdata);
        end
    endtask

`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h82);
        n_tests++;
        if ({req_valid, req_addr, drop_count} !== {1'b1, 16'h1234, 8'd0}) begin
            n_fail++; $display("FAIL csum_good: got v=%b a=%h drops=%0d want 1 1234 0", req_valid, req_addr, drop_count);
        end
        do_reset();
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        n_tests++;
        if ({req_valid, drop_count} !== {1'b0, 8'd1}) begin
            n_fail++; $display("FAIL csum_bad: got v=%b drops=%0d want 0 1", req_valid, drop_count);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_write();
        test_fifo_full_drop();
        test_full_push_pop();
        test_gap_timeout();
        test_tx_stall();
        test_back_to_back();
        test_wide();
        test_reset_mid_frame();
`ifdef BUS_BRIDGE_UART_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
